// File: rtl/rf_pkg.sv
// Shared sizes and types for the register-file write-back path.
package rf_pkg;
  localparam int AW     = 5;
  localparam int NREG   = 2 ** AW;
  localparam int DATA_W = 32;

  typedef logic [AW-1:0] reg_addr_t;

  typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} grant_t;
endpackage

// File: rtl/decoder5_32.sv
// 5-to-32 one-hot decoder with an enable; all zeros when disabled.
module decoder5_32 (
  input  logic [4:0]  addr_i,
  input  logic        en_i,
  output logic [31:0] onehot_o
);
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end
endmodule

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the side not granted on the previous tie wins the next tie.
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  grant_t last_q, last_d;

  // last_q only moves on a tie so a lone requester never disturbs the fairness order
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        if (last_q == GNT_MEM) begin
          gnt_o  = 2'b01;
          last_d = GNT_ALU;
        end else begin
          gnt_o  = 2'b10;
          last_d = GNT_MEM;
        end
      end
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= GNT_MEM;
    else       last_q <= last_d;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter (ALU vs load return) with a pending-write scoreboard
// that lets decode stall on RAW and WAW hazards.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  reg_addr_t         alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  reg_addr_t         mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  reg_addr_t         issue_rd,
  output logic              issue_ready,
  input  reg_addr_t         ra,
  input  reg_addr_t         rb,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              rf_en,
  output reg_addr_t         rf_rw,
  output logic [DATA_W-1:0] rf_busw,
  output logic [NREG-1:0]   pending
);
  logic [1:0]        gnt;
  logic              en_q, en_d;
  reg_addr_t         rw_q, rw_d;
  logic [DATA_W-1:0] busw_q, busw_d;
  logic [NREG-1:0]   pend_q, pend_d, setVec, clrVec;
  logic              issueFire;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i ({mem_valid, alu_valid}),
    .gnt_o (gnt)
  );

  assign alu_ready = gnt[GNT_ALU];
  assign mem_ready = gnt[GNT_MEM];

  // r0 is hardwired zero, so its write-backs handshake but never reach the write port
  always_comb begin
    en_d   = 1'b0;
    rw_d   = rw_q;
    busw_d = busw_q;
    if (alu_ready) begin
      en_d   = (alu_rd != '0);
      rw_d   = alu_rd;
      busw_d = alu_data;
    end else if (mem_ready) begin
      en_d   = (mem_rd != '0);
      rw_d   = mem_rd;
      busw_d = mem_data;
    end
  end

  assign issue_ready = !pend_q[issue_rd] || (issue_rd == '0);
  assign issueFire   = issue_valid && issue_ready && (issue_rd != '0);

  decoder5_32 u_setDec (
    .addr_i   (issue_rd),
    .en_i     (issueFire),
    .onehot_o (setVec)
  );

  decoder5_32 u_clrDec (
    .addr_i   (rw_q),
    .en_i     (en_q),
    .onehot_o (clrVec)
  );

  // A new issue must survive the retiring write of an older one to the same register
  assign pend_d = (pend_q & ~clrVec) | setVec;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= 1'b0;
      rw_q   <= '0;
      busw_q <= '0;
      pend_q <= '0;
    end else begin
      en_q   <= en_d;
      rw_q   <= rw_d;
      busw_q <= busw_d;
      pend_q <= pend_d;
    end
  end

  assign hazard_a = pend_q[ra] && (ra != '0);
  assign hazard_b = pend_q[rb] && (rb != '0);

  assign rf_en   = en_q;
  assign rf_rw   = rw_q;
  assign rf_busw = busw_q;
  assign pending = pend_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by random traffic,
// all compared against a behavioural model of the arbiter and scoreboard.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid, mem_valid, issue_valid;
  reg_addr_t         alu_rd, mem_rd, issue_rd, ra, rb;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_ready, mem_ready, issue_ready, hazard_a, hazard_b, rf_en;
  reg_addr_t         rf_rw;
  logic [DATA_W-1:0] rf_busw;
  logic [NREG-1:0]   pending;

  int checkCount = 0;
  int failCount  = 0;

  // Behavioural model: pending set as an array, tie history, and the expected write-port contents
  bit                mPend[NREG];
  bit                mLastMem;
  bit                mEn;
  int                mRw;
  logic [DATA_W-1:0] mBus;
  bit                mAluAcc, mMemAcc;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .ra          (ra),
    .rb          (rb),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .rf_en       (rf_en),
    .rf_rw       (rf_rw),
    .rf_busw     (rf_busw),
    .pending     (pending)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    foreach (mPend[i]) mPend[i] = 1'b0;
    mLastMem = 1'b1;
    mEn      = 1'b0;
    mRw      = 0;
    mBus     = '0;
    mAluAcc  = 1'b0;
    mMemAcc  = 1'b0;
  endtask

  // Compare every visible output with what the model predicts for the current cycle
  task automatic checkAll();
    bit              expAlu, expMem;
    logic [NREG-1:0] expPend;
    expAlu = alu_valid && (!mem_valid || mLastMem);
    expMem = mem_valid && (!alu_valid || !mLastMem);
    for (int i = 0; i < NREG; i++) expPend[i] = mPend[i];
    checkOutput("alu_ready", alu_ready, expAlu);
    checkOutput("mem_ready", mem_ready, expMem);
    checkOutput("issue_ready", issue_ready, (!mPend[issue_rd]) || (issue_rd == 0));
    checkOutput("hazard_a", hazard_a, mPend[ra] && (ra != 0));
    checkOutput("hazard_b", hazard_b, mPend[rb] && (rb != 0));
    checkOutput("rf_en", rf_en, mEn);
    if (mEn) begin
      checkOutput("rf_rw", rf_rw, mRw);
      checkOutput("rf_busw", rf_busw, mBus);
    end
    checkOutput("pending", pending, expPend);
  endtask

  task automatic stepModel();
    bit issueSet;
    if (reset) begin
      modelReset();
      return;
    end
    mAluAcc = 1'b0;
    mMemAcc = 1'b0;
    if (alu_valid && mem_valid) begin
      mAluAcc  = mLastMem;
      mMemAcc  = !mLastMem;
      mLastMem = mMemAcc;
    end else begin
      mAluAcc = alu_valid;
      mMemAcc = mem_valid;
    end
    issueSet = issue_valid && (issue_rd != 0) && !mPend[issue_rd];
    if (mEn) mPend[mRw] = 1'b0;
    if (issueSet) mPend[issue_rd] = 1'b1;
    if (mAluAcc) begin
      mEn = (alu_rd != 0); mRw = alu_rd; mBus = alu_data;
    end else if (mMemAcc) begin
      mEn = (mem_rd != 0); mRw = mem_rd; mBus = mem_data;
    end else begin
      mEn = 1'b0;
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    checkAll();
    @(posedge clk);
    stepModel();
    #1;
  endtask

  task automatic idleInputs();
    alu_valid   = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid   = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    ra = '0; rb = '0;
  endtask

  initial begin
    int aluRdSeq[4], memRdSeq[4], expRwSeq[4];
    bit expAluWin[4];

    idleInputs();
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset rf_en", rf_en, 0);
    checkOutput("reset rf_rw", rf_rw, 0);
    checkOutput("reset rf_busw", rf_busw, 0);
    checkOutput("reset pending", pending, 0);

    // ALU alone writes r5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 checkOutput("t1 alu_ready", alu_ready, 1);
    applyStimulus();
    idleInputs();
    #1;
    checkOutput("t1 rf_en N+1", rf_en, 1);
    checkOutput("t1 rf_rw N+1", rf_rw, 5);
    checkOutput("t1 rf_busw N+1", rf_busw, 32'hDEADBEEF);
    applyStimulus();
    checkOutput("t1 rf_en N+2", rf_en, 0);

    // Four-cycle tie: losers hold their request until granted
    aluRdSeq  = '{10, 11, 11, 12};
    memRdSeq  = '{20, 20, 21, 21};
    expRwSeq  = '{10, 20, 11, 21};
    expAluWin = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = aluRdSeq[i]; alu_data = 32'hA000_0000 | aluRdSeq[i];
      mem_valid = 1'b1; mem_rd = memRdSeq[i]; mem_data = 32'hB000_0000 | memRdSeq[i];
      #1 checkOutput("rr alu_ready", alu_ready, expAluWin[i]);
      applyStimulus();
      checkOutput("rr rf_rw", rf_rw, expRwSeq[i]);
    end
    idleInputs();
    applyStimulus();

    // Scoreboard on r7 with a refused second issue
    issue_valid = 1'b1; issue_rd = 5'd7; ra = 5'd7;
    applyStimulus();
    issue_valid = 1'b0;
    #1;
    checkOutput("r7 pending", pending[7], 1);
    checkOutput("r7 hazard_a", hazard_a, 1);
    issue_valid = 1'b1;
    #1 checkOutput("r7 second issue_ready", issue_ready, 0);
    applyStimulus();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234_5678;
    applyStimulus();
    mem_valid = 1'b0;
    #1;
    checkOutput("r7 write cycle rf_en", rf_en, 1);
    checkOutput("r7 write cycle hazard_a", hazard_a, 1);
    applyStimulus();
    checkOutput("r7 after write hazard_a", hazard_a, 0);
    checkOutput("r7 issue_ready back", issue_ready, 1);

    // r0 traffic never writes nor marks pending
    idleInputs();
    alu_valid = 1'b1; mem_valid = 1'b1; issue_valid = 1'b1;
    alu_data = 32'hFFFF_FFFF; mem_data = 32'hEEEE_EEEE;
    repeat (3) begin
      applyStimulus();
      checkOutput("r0 rf_en", rf_en, 0);
      checkOutput("r0 pending", pending, 0);
      checkOutput("r0 hazard_a", hazard_a, 0);
    end
    idleInputs();
    applyStimulus();

    // Clear of r3 on the same edge as the issue of r4
    issue_valid = 1'b1; issue_rd = 5'd3;
    applyStimulus();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
    applyStimulus();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd4;
    applyStimulus();
    issue_valid = 1'b0;
    checkOutput("clr3 pending[3]", pending[3], 0);
    checkOutput("set4 pending[4]", pending[4], 1);

    // Reset the cycle after a tie handshake that moved the round-robin pointer to ALU
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0000;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h8888_0000;
    issue_valid = 1'b1; issue_rd = 5'd12;
    applyStimulus();
    idleInputs();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("mid reset rf_en", rf_en, 0);
    checkOutput("mid reset pending", pending, 0);
    alu_valid = 1'b1; alu_rd = 5'd1; mem_valid = 1'b1; mem_rd = 5'd2;
    #1 checkOutput("mid reset tie to alu", alu_ready, 1);
    applyStimulus();

    // Random traffic: producers hold until accepted, small register range for collisions
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!alu_valid || mAluAcc || reset) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = $urandom_range(0, 7);
        alu_data  = $urandom;
      end
      if (!mem_valid || mMemAcc || reset) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = $urandom_range(0, 7);
        mem_data  = $urandom;
      end
      issue_valid = $urandom_range(0, 1);
      issue_rd    = $urandom_range(0, 7);
      ra          = $urandom_range(0, 7);
      rb          = $urandom_range(0, 31);
      reset       = ($urandom_range(0, 79) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
